// File: rtl/fleet_placer_if.sv
// Mouse/start inputs and cell-memory control signals exchanged with fleet_placer.
interface fleet_placer_if;
    logic       start;
    logic       left_click_in;
    logic       right_click_in;
    logic       ship_placed;
    logic [1:0] play_status;
    logic [2:0] dimension;
    logic       direction;
    logic       we;
    logic [2:0] ships_left;
    logic       place_error;
    logic       placement_done;

    modport master (
        output start, left_click_in, right_click_in, ship_placed,
        input  play_status, dimension, direction, we, ships_left, place_error, placement_done
    );

    modport slave (
        input  start, left_click_in, right_click_in, ship_placed,
        output play_status, dimension, direction, we, ships_left, place_error, placement_done
    );
endinterface

// File: rtl/fleet_placer.sv
// Fleet deployment sequencer: walks the ship list, commits on left click, rotates on right click,
// and advances or retries based on the cell memory's ship_placed reply.
module fleet_placer #(
    parameter int unsigned                NUM_SHIPS   = 5,
    parameter logic [3*NUM_SHIPS-1:0]     FLEET_SIZES = 15'b010_011_011_100_100
) (
    input  logic          clk_in,
    input  logic          rst_in,
    fleet_placer_if.slave bus
);
    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SHIPS - 1);
    localparam logic [IDX_W-1:0] SHIP_CNT  = IDX_W'(NUM_SHIPS);

    typedef enum logic [1:0] {IDLE, PLACE, COMMIT, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] ship_idx;
    logic [1:0]       play_status;
    logic [2:0]       dimension;
    logic             direction;
    logic             we;
    logic [2:0]       ships_left;
    logic             place_error;
    logic             placement_done;

    // Click conditioning: [0]=sync1, [1]=sync2, [2]=history
    logic [2:0] left_sync;
    logic [2:0] right_sync;
    logic       left_edge;
    logic       right_edge;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            left_sync  <= '0;
            right_sync <= '0;
        end else begin
            left_sync  <= {left_sync[1:0], bus.left_click_in};
            right_sync <= {right_sync[1:0], bus.right_click_in};
        end
    end

    assign left_edge  = left_sync[1] & ~left_sync[2];
    assign right_edge = right_sync[1] & ~right_sync[2];

    function automatic logic [2:0] size_of(input logic [IDX_W-1:0] idx);
        logic [2:0] sz;
        sz = 3'd0;
        for (int unsigned i = 0; i < NUM_SHIPS; i++) begin
            if (IDX_W'(i) == idx) sz = FLEET_SIZES[3*i +: 3];
        end
        return sz;
    endfunction

    // State register with registered Moore outputs computed alongside the next state
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            ship_idx       <= '0;
            play_status    <= 2'b00;
            dimension      <= 3'd0;
            direction      <= 1'b0;
            we             <= 1'b0;
            ships_left     <= SHIP_CNT;
            place_error    <= 1'b0;
            placement_done <= 1'b0;
        end else begin
            we          <= 1'b0;
            place_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= PLACE;
                        ship_idx    <= '0;
                        direction   <= 1'b0;
                        play_status <= 2'b01;
                        dimension   <= size_of('0);
                    end
                end
                PLACE: begin
                    if (left_edge) begin
                        state <= COMMIT;
                        we    <= 1'b1;
                    end else if (right_edge) begin
                        direction <= ~direction;
                    end
                end
                COMMIT: begin
                    if (bus.ship_placed) begin
                        ship_idx <= ship_idx + IDX_W'(1);
                        if (ships_left != 3'd0) ships_left <= ships_left - 3'd1;
                        if (ship_idx == LAST_IDX) begin
                            state          <= DONE;
                            play_status    <= 2'b10;
                            dimension      <= 3'd0;
                            placement_done <= 1'b1;
                        end else begin
                            state     <= PLACE;
                            dimension <= size_of(ship_idx + IDX_W'(1));
                        end
                    end else begin
                        // Rejected placement: retry the same ship
                        state       <= PLACE;
                        place_error <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.play_status    = play_status;
    assign bus.dimension      = dimension;
    assign bus.direction      = direction;
    assign bus.we             = we;
    assign bus.ships_left     = ships_left;
    assign bus.place_error    = place_error;
    assign bus.placement_done = placement_done;
endmodule

// File: tb/tb_fleet_placer.sv
// Directed bench for fleet_placer: reset, rotation, accepted/rejected commits, and DONE behaviour.
module tb_fleet_placer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    fleet_placer_if bus();

    fleet_placer dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Left click (optionally with a simultaneous right click); checks the we timing and COMMIT hold
    task automatic press_left(input logic accept, input logic with_right,
                              input logic [2:0] cur_dim, input logic cur_dir);
        bus.ship_placed    = accept;
        bus.left_click_in  = 1'b1;
        bus.right_click_in = with_right;
        tick();
        tick();
        chk("we_before_latency", bus.we, 8'd0);
        tick();
        chk("we_at_latency", bus.we, 8'd1);
        chk("commit_dim_held", bus.dimension, cur_dim);
        chk("commit_dir_held", bus.direction, cur_dir);
        tick();
        chk("we_single_cycle", bus.we, 8'd0);
        chk("place_error_pulse", bus.place_error, accept ? 8'd0 : 8'd1);
        chk("dir_after_commit", bus.direction, cur_dir);
        bus.left_click_in  = 1'b0;
        bus.right_click_in = 1'b0;
        tick();
        chk("place_error_cleared", bus.place_error, 8'd0);
        chk("we_still_low", bus.we, 8'd0);
        tick();
        tick();
    endtask

    task automatic press_right();
        bus.right_click_in = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        bus.start          = 1'b0;
        bus.left_click_in  = 1'b0;
        bus.right_click_in = 1'b0;
        bus.ship_placed    = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_status", bus.play_status, 8'd0);
        chk("rst_ships_left", bus.ships_left, 8'd5);
        rst = 1'b0;
        tick();

        // Start, then reset asynchronously in the middle of a COMMIT
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_status", bus.play_status, 8'd1);
        bus.left_click_in = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_reset_we", bus.we, 8'd1);
        rst = 1'b1;
        bus.left_click_in = 1'b0;
        #1;
        chk("midcommit_rst_status", bus.play_status, 8'd0);
        chk("midcommit_rst_dim", bus.dimension, 8'd0);
        chk("midcommit_rst_we", bus.we, 8'd0);
        chk("midcommit_rst_dir", bus.direction, 8'd0);
        chk("midcommit_rst_left", bus.ships_left, 8'd5);
        chk("midcommit_rst_err", bus.place_error, 8'd0);
        chk("midcommit_rst_done", bus.placement_done, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("idle_stays_idle", bus.play_status, 8'd0);

        // Start deployment
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("deploy_status", bus.play_status, 8'd1);
        chk("deploy_dim", bus.dimension, 8'd4);
        chk("deploy_dir", bus.direction, 8'd0);
        chk("deploy_left", bus.ships_left, 8'd5);
        chk("deploy_we", bus.we, 8'd0);

        // Right click held 10 cycles: one toggle, 3 cycles after the rise
        press_right();
        chk("rot_not_yet", bus.direction, 8'd0);
        tick();
        chk("rot_toggled", bus.direction, 8'd1);
        for (int i = 0; i < 7; i++) tick();
        chk("rot_held_once", bus.direction, 8'd1);
        bus.right_click_in = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        press_right();
        tick();
        chk("rot_back", bus.direction, 8'd0);
        bus.right_click_in = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Ship 0 accepted
        press_left(1'b1, 1'b0, 3'd4, 1'b0);
        chk("s1_dim", bus.dimension, 8'd4);
        chk("s1_left", bus.ships_left, 8'd4);

        // Ship 1 rejected, then retried and accepted
        press_left(1'b0, 1'b0, 3'd4, 1'b0);
        chk("rej_dim", bus.dimension, 8'd4);
        chk("rej_left", bus.ships_left, 8'd4);
        chk("rej_status", bus.play_status, 8'd1);
        press_left(1'b1, 1'b0, 3'd4, 1'b0);
        chk("s2_dim", bus.dimension, 8'd3);
        chk("s2_left", bus.ships_left, 8'd3);

        // Rotate, direction carries over into the next ship
        press_right();
        tick();
        bus.right_click_in = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("s2_rotated", bus.direction, 8'd1);
        press_left(1'b1, 1'b0, 3'd3, 1'b1);
        chk("s3_dim", bus.dimension, 8'd3);
        chk("s3_left", bus.ships_left, 8'd2);
        chk("s3_dir_kept", bus.direction, 8'd1);

        // Simultaneous left+right: commit wins, no rotation
        press_left(1'b1, 1'b1, 3'd3, 1'b1);
        chk("s4_dim", bus.dimension, 8'd2);
        chk("s4_left", bus.ships_left, 8'd1);
        chk("s4_dir_kept", bus.direction, 8'd1);

        // Last ship -> DONE
        press_left(1'b1, 1'b0, 3'd2, 1'b1);
        chk("done_status", bus.play_status, 8'd2);
        chk("done_flag", bus.placement_done, 8'd1);
        chk("done_dim", bus.dimension, 8'd0);
        chk("done_left", bus.ships_left, 8'd0);

        // Clicks and start ignored in DONE
        bus.left_click_in = 1'b1;
        bus.ship_placed   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("done_no_we", bus.we, 8'd0);
        end
        bus.left_click_in = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("done_start_ignored", bus.play_status, 8'd2);
        chk("done_left_stays", bus.ships_left, 8'd0);
        chk("done_flag_stays", bus.placement_done, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
